controller_conditioner: RTL and testbench
=========================================

Name: controller_conditioner

Overview:
- Front-end for the 5-bit controller_in bus that feeds the CPU's memory-mapped controller port.
- Takes raw board push-buttons and synchronizes each one into clk, then debounces it.
- Produces three kinds of output: clean levels, single-cycle press/release pulses, and auto-repeat strobes.
- Also holds sticky event bits that software clears explicitly, so no button press is lost while the CPU is busy.

Parameters:
- N_BUTTONS, 5, number of independent button channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a level change (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000, hold time in cycles before the first auto-repeat strobe.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat strobes.
- ACTIVE_LOW, 1, raw inputs read 0 when pressed (board keys); 0 means active-high.

Ports:
- clk, in, 1, system clock (50 MHz).
- reset, in, 1, synchronous, active-low reset.
- btn_raw, in, N_BUTTONS, asynchronous raw button pins.
- clear_events, in, 1, one-cycle request to clear all sticky event bits.
- level, out, N_BUTTONS, debounced pressed state (1 = pressed); drives controller_in.
- press, out, N_BUTTONS, one-cycle pulse on an accepted press.
- release_p, out, N_BUTTONS, one-cycle pulse on an accepted release.
- strobe, out, N_BUTTONS, press pulse OR auto-repeat pulse.
- events, out, N_BUTTONS, sticky flags set by strobe.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All outputs go to 0.
  - Synchronizer flops load the released value.
  - Counters go to 0; every FSM goes to IDLE.
  - Reset has priority over every other input.
- Polarity: p = btn_raw XOR ACTIVE_LOW, so p = 1 means pressed.
- Synchronizer: 2-flop chain per bit, s1 <= p, s2 <= s1. No logic sits between the two flops.
- Debounce, per bit, with a counter of width clog2(DEBOUNCE_CYCLES+1):
  - If s2 == level: the counter clears.
  - Else: the counter increments.
  - When the counter would reach DEBOUNCE_CYCLES: level <= s2 and the counter clears on that same edge.
  - Any mismatch run shorter than DEBOUNCE_CYCLES produces no output change.
  - Latency: a clean raw change is visible on level exactly DEBOUNCE_CYCLES+2 edges after it is first sampled.
- Pulses (registered, asserted in the same cycle level changes):
  - press = rising edge of level.
  - release_p = falling edge of level.
- Repeat FSM, per bit, with a repeat counter of width clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1):
  - IDLE: on an accepted press, go to DELAY and clear the counter.
  - DELAY: count while level==1. On reaching REPEAT_DELAY, pulse a repeat, go to REPEAT, clear the counter.
  - REPEAT: count. On reaching REPEAT_PERIOD, pulse a repeat and clear the counter.
  - From DELAY or REPEAT: level falling goes to IDLE immediately with the counter cleared. No repeat pulse is issued in the release cycle.
- strobe = press | repeat_pulse. Both are single-cycle; they never overlap because repeats start at least REPEAT_DELAY cycles after press.
- events[i]:
  - Set when strobe[i] is 1.
  - Cleared to 0 on clear_events.
  - If set and clear happen in the same cycle, set wins (events[i] = 1). Bits that are not setting clear.
- Channels are fully independent. Simultaneous presses on several bits each behave as if alone.
- A button held through reset deassertion is treated as a fresh press: level rises DEBOUNCE_CYCLES+2 edges after reset goes high.
- Parameter constraints:
  - DEBOUNCE_CYCLES >= 1.
  - REPEAT_DELAY, REPEAT_PERIOD >= 2.
  - Violations are caught by an elaboration-time check.

Decomposition:
- Shared package ctrl_pkg holds:
  - repeat-FSM state encoding: IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2;
  - bit-index constants for the five controller buttons;
  - the default timing constants.
- Sub-module button_channel implements one bit: synchronizer, debounce, edge pulses and repeat FSM.
- The top generates N_BUTTONS instances and keeps the events register with its clear logic.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW=1):
- Reset: hold reset=0 for 3 cycles with btn_raw=5'b00000 (all pressed). All outputs stay 0 throughout; after release, level becomes 5'b11111 exactly 6 edges later, and press pulses 5'b11111 for one cycle.
- Glitch rejection: bit0 low for 3 cycles, then high. level, press and events stay 0; the debounce counter returns to 0.
- Clean press/hold/release on bit2:
  - level[2] rises 6 edges after the raw edge, with press[2] for one cycle.
  - strobe[2] fires at press, then 10 cycles later, then every 3 cycles.
  - On release, release_p[2] pulses once and no further strobes occur.
- Sticky events: press bit1, then assert clear_events in the same cycle as a second bit1 repeat strobe. events[1] stays 1. A later clear with no strobe gives events=0.
- Independence: bits 3 and 4 are pressed 1 cycle apart. Their level and press pulses are offset by exactly 1 cycle, and the other bits are unaffected.
- Reset mid-hold: assert reset during REPEAT. All outputs go to 0 on that edge and the FSM returns to IDLE. After release with the button still held, a new press pulse appears after 6 edges.

Source files
------------

// File: rtl/controller_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared types and constants for the controller input
//               conditioner: repeat-FSM encoding, button bit indices and
//               default timing values.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Per-channel auto-repeat state machine encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    // Bit positions of the five controller buttons on controller_in
    localparam int c_btn_right = 0;
    localparam int c_btn_left  = 1;
    localparam int c_btn_down  = 2;
    localparam int c_btn_up    = 3;
    localparam int c_btn_fire  = 4;

    // Default timing at 50 MHz
    localparam int c_n_buttons_dflt       = 5;
    localparam int c_debounce_cycles_dflt = 500000;
    localparam int c_repeat_delay_dflt    = 25000000;
    localparam int c_repeat_period_dflt   = 5000000;
    localparam int c_active_low_dflt      = 1;

    // Larger of two integers, used to size the shared repeat counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/controller_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : controller_conditioner_if
// Description : Button/controller bus between the board-side producer and
//               the conditioner. master drives raw buttons and clear;
//               slave (the conditioner) drives the cleaned outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface controller_conditioner_if #(
    parameter int N_BUTTONS = 5
);
    logic [N_BUTTONS-1:0] btn_raw;
    logic                 clear_events;
    logic [N_BUTTONS-1:0] level;
    logic [N_BUTTONS-1:0] press;
    logic [N_BUTTONS-1:0] release_p;
    logic [N_BUTTONS-1:0] strobe;
    logic [N_BUTTONS-1:0] events;

    modport master (
        output btn_raw,
        output clear_events,
        input  level,
        input  press,
        input  release_p,
        input  strobe,
        input  events
    );

    modport slave (
        input  btn_raw,
        input  clear_events,
        output level,
        output press,
        output release_p,
        output strobe,
        output events
    );
endinterface
`default_nettype wire

// File: rtl/controller_conditioner_button_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_channel
// Description : One button: polarity fix, 2-flop synchronizer, debounce,
//               registered press/release pulses and auto-repeat FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module button_channel
    import ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles_dflt,
    parameter int REPEAT_DELAY    = c_repeat_delay_dflt,
    parameter int REPEAT_PERIOD   = c_repeat_period_dflt,
    parameter int ACTIVE_LOW      = c_active_low_dflt
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_btn_raw,
    output logic      o_level,
    output logic      o_press,
    output logic      o_release,
    output logic      o_strobe
);

    localparam int c_db_w      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_rep_max   = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int c_rep_w     = $clog2(c_rep_max + 1);
    localparam logic [c_db_w-1:0]  c_db_last     = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_rep_w-1:0] c_delay_last  = c_rep_w'(REPEAT_DELAY - 1);
    localparam logic [c_rep_w-1:0] c_period_last = c_rep_w'(REPEAT_PERIOD - 1);
    localparam logic c_pol = (ACTIVE_LOW != 0);

    logic               w_p;
    logic               w_rise;
    logic               w_fall;
    logic               w_rep_pulse;

    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic               level_q, level_d;
    logic [c_db_w-1:0]  db_cnt_q, db_cnt_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               strobe_q, strobe_d;
    rep_state_t         rep_state_q, rep_state_d;
    logic [c_rep_w-1:0] rep_cnt_q, rep_cnt_d;

    // After the XOR, 1 always means pressed
    assign w_p = i_btn_raw ^ c_pol;

    // Next-state: synchronizer, debounce, edge pulses and repeat FSM
    always_comb begin
        s1_d        = w_p;
        s2_d        = s1_q;

        // A level change is accepted only after DEBOUNCE_CYCLES mismatches in a row
        level_d     = level_q;
        db_cnt_d    = '0;
        if (s2_q != level_q) begin
            if (db_cnt_q == c_db_last) begin
                level_d  = s2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        w_rise      = level_d & ~level_q;
        w_fall      = ~level_d & level_q;
        press_d     = w_rise;
        release_d   = w_fall;

        rep_state_d = rep_state_q;
        rep_cnt_d   = rep_cnt_q;
        w_rep_pulse = 1'b0;
        case (rep_state_q)
            IDLE: begin
                if (w_rise) begin
                    rep_state_d = DELAY;
                    rep_cnt_d   = '0;
                end
            end
            DELAY: begin
                if (w_fall) begin
                    rep_state_d = IDLE;
                    rep_cnt_d   = '0;
                end else if (rep_cnt_q == c_delay_last) begin
                    w_rep_pulse = 1'b1;
                    rep_state_d = REPEAT;
                    rep_cnt_d   = '0;
                end else begin
                    rep_cnt_d   = rep_cnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (w_fall) begin
                    rep_state_d = IDLE;
                    rep_cnt_d   = '0;
                end else if (rep_cnt_q == c_period_last) begin
                    w_rep_pulse = 1'b1;
                    rep_cnt_d   = '0;
                end else begin
                    rep_cnt_d   = rep_cnt_q + 1'b1;
                end
            end
            default: begin
                rep_state_d = IDLE;
                rep_cnt_d   = '0;
            end
        endcase

        // Press and repeat pulses are at least REPEAT_DELAY apart, so OR is safe
        strobe_d    = w_rise | w_rep_pulse;
    end

    // State registers; reset loads the released value everywhere
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            level_q     <= 1'b0;
            db_cnt_q    <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            strobe_q    <= 1'b0;
            rep_state_q <= IDLE;
            rep_cnt_q   <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            level_q     <= level_d;
            db_cnt_q    <= db_cnt_d;
            press_q     <= press_d;
            release_q   <= release_d;
            strobe_q    <= strobe_d;
            rep_state_q <= rep_state_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_strobe  = strobe_q;

endmodule
`default_nettype wire

// File: rtl/controller_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : controller_conditioner
// Description : Conditions N_BUTTONS raw push-buttons into debounced levels,
//               press/release pulses, auto-repeat strobes and sticky,
//               software-cleared event flags for the CPU controller port.
// Revision    : 1.0 - initial release
// ============================================================================
module controller_conditioner
    import ctrl_pkg::*;
#(
    parameter int N_BUTTONS       = c_n_buttons_dflt,
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles_dflt,
    parameter int REPEAT_DELAY    = c_repeat_delay_dflt,
    parameter int REPEAT_PERIOD   = c_repeat_period_dflt,
    parameter int ACTIVE_LOW      = c_active_low_dflt
) (
    input  wire logic               clk,
    input  wire logic               reset,
    controller_conditioner_if.slave bus
);

    // Reject timing values the counters cannot represent sensibly
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
        $error("controller_conditioner: DEBOUNCE_CYCLES>=1 and REPEAT_DELAY/REPEAT_PERIOD>=2 required");
    end

    logic [N_BUTTONS-1:0] w_level;
    logic [N_BUTTONS-1:0] w_press;
    logic [N_BUTTONS-1:0] w_release;
    logic [N_BUTTONS-1:0] w_strobe;
    logic [N_BUTTONS-1:0] events_q, events_d;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .i_btn_raw (bus.btn_raw[i]),
            .o_level   (w_level[i]),
            .o_press   (w_press[i]),
            .o_release (w_release[i]),
            .o_strobe  (w_strobe[i])
        );
    end

    // Sticky flags: a strobe in the same cycle as a clear keeps its bit set
    always_comb begin
        events_d = (events_q & ~{N_BUTTONS{bus.clear_events}}) | w_strobe;
    end

    // Event register
    always_ff @(posedge clk) begin
        if (!reset) begin
            events_q <= '0;
        end else begin
            events_q <= events_d;
        end
    end

    assign bus.level     = w_level;
    assign bus.press     = w_press;
    assign bus.release_p = w_release;
    assign bus.strobe    = w_strobe;
    assign bus.events    = events_q;

endmodule
`default_nettype wire

// File: tb/tb_controller_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_controller_conditioner
// Description : Directed self-checking bench for controller_conditioner with
//               DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3,
//               ACTIVE_LOW=1. Edge counts in comments are relative to the
//               edge at which the accepted level change appears (P).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controller_conditioner;
    import ctrl_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    controller_conditioner_if #(.N_BUTTONS(5)) bus ();

    controller_conditioner #(
        .N_BUTTONS       (5),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .ACTIVE_LOW      (1)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit after the last one
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pulse();
        bus.clear_events = 1'b1;
        tick(1);
        bus.clear_events = 1'b0;
    endtask

    initial begin
        checks             = 0;
        failures           = 0;
        reset              = 1'b0;
        bus.btn_raw        = 5'b00000;
        bus.clear_events   = 1'b0;

        // ---- Reset held with all buttons pressed: everything stays 0
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_level",   32'(bus.level),     32'h00);
            chk("rst_press",   32'(bus.press),     32'h00);
            chk("rst_release", 32'(bus.release_p), 32'h00);
            chk("rst_strobe",  32'(bus.strobe),    32'h00);
            chk("rst_events",  32'(bus.events),    32'h00);
        end
        reset = 1'b1;
        tick(5);
        chk("por_level_e5",   32'(bus.level),  32'h00);
        tick(1);                                            // P
        chk("por_level_e6",   32'(bus.level),  32'h1F);
        chk("por_press",      32'(bus.press),  32'h1F);
        chk("por_strobe",     32'(bus.strobe), 32'h1F);
        chk("por_events_lag", 32'(bus.events), 32'h00);
        tick(1);                                            // P+1
        chk("por_press_end",  32'(bus.press),  32'h00);
        chk("por_events_set", 32'(bus.events), 32'h1F);
        bus.btn_raw = 5'b11111;
        tick(5);                                            // P+6
        chk("all_rel_early",  32'(bus.level),     32'h1F);
        tick(1);                                            // P+7
        chk("all_rel_level",  32'(bus.level),     32'h00);
        chk("all_rel_pulse",  32'(bus.release_p), 32'h1F);
        chk("all_rel_strobe", 32'(bus.strobe),    32'h00);
        tick(1);
        chk("all_rel_pulse_end", 32'(bus.release_p), 32'h00);
        clear_pulse();
        chk("all_clear", 32'(bus.events), 32'h00);
        tick(12);
        chk("all_no_repeat", 32'(bus.events), 32'h00);

        // ---- Glitch: bit0 pressed for 3 cycles only
        bus.btn_raw = 5'b11110;
        tick(3);
        bus.btn_raw = 5'b11111;
        tick(2);
        chk("glitch_cnt_peak", 32'(u_dut.g_chan[0].u_ch.db_cnt_q), 32'd3);
        tick(1);
        chk("glitch_cnt_zero", 32'(u_dut.g_chan[0].u_ch.db_cnt_q), 32'd0);
        chk("glitch_level",    32'(bus.level), 32'h00);
        tick(10);
        chk("glitch_level_late", 32'(bus.level),  32'h00);
        chk("glitch_events",     32'(bus.events), 32'h00);

        // ---- Clean press / hold / release on bit2
        bus.btn_raw = 5'b11011;
        tick(5);
        chk("b2_level_e5", 32'(bus.level), 32'h00);
        tick(1);                                            // P
        chk("b2_level",  32'(bus.level),  32'h04);
        chk("b2_press",  32'(bus.press),  32'h04);
        chk("b2_strobe", 32'(bus.strobe), 32'h04);
        tick(1);                                            // P+1
        chk("b2_press_end",  32'(bus.press),  32'h00);
        chk("b2_strobe_end", 32'(bus.strobe), 32'h00);
        tick(8);                                            // P+9
        chk("b2_no_early_rep", 32'(bus.strobe), 32'h00);
        tick(1);                                            // P+10
        chk("b2_rep1",       32'(bus.strobe), 32'h04);
        chk("b2_rep1_press", 32'(bus.press),  32'h00);
        tick(1);                                            // P+11
        chk("b2_rep1_end", 32'(bus.strobe), 32'h00);
        tick(1);                                            // P+12
        chk("b2_gap", 32'(bus.strobe), 32'h00);
        tick(1);                                            // P+13
        chk("b2_rep2", 32'(bus.strobe), 32'h04);
        tick(3);                                            // P+16
        chk("b2_rep3", 32'(bus.strobe), 32'h04);
        bus.btn_raw = 5'b11111;
        tick(3);                                            // P+19
        chk("b2_rep4",       32'(bus.strobe), 32'h04);
        chk("b2_still_held", 32'(bus.level),  32'h04);
        tick(3);                                            // P+22
        chk("b2_rel_level",  32'(bus.level),     32'h00);
        chk("b2_rel_pulse",  32'(bus.release_p), 32'h04);
        chk("b2_rel_strobe", 32'(bus.strobe),    32'h00);
        tick(1);                                            // P+23
        chk("b2_rel_pulse_end", 32'(bus.release_p), 32'h00);
        clear_pulse();
        chk("b2_clear", 32'(bus.events), 32'h00);
        tick(12);
        chk("b2_no_strobe_after_rel", 32'(bus.events), 32'h00);

        // ---- Sticky events on bit1: set beats clear in the same cycle
        bus.btn_raw = 5'b11101;
        tick(6);                                            // P
        chk("b1_level",  32'(bus.level),  32'h02);
        chk("b1_strobe", 32'(bus.strobe), 32'h02);
        tick(1);                                            // P+1
        chk("b1_events", 32'(bus.events), 32'h02);
        tick(12);                                           // P+13
        chk("b1_rep2", 32'(bus.strobe), 32'h02);
        clear_pulse();                                      // P+14
        chk("b1_set_wins", 32'(bus.events), 32'h02);
        clear_pulse();                                      // P+15
        chk("b1_clear", 32'(bus.events), 32'h00);
        bus.btn_raw = 5'b11111;
        tick(7);                                            // P+22
        chk("b1_rel_level", 32'(bus.level), 32'h00);
        clear_pulse();
        chk("b1_clear_after_rel", 32'(bus.events), 32'h00);

        // ---- Independence: bit3 then bit4 one cycle later
        bus.btn_raw = 5'b10111;
        tick(1);
        bus.btn_raw = 5'b00111;
        tick(4);
        chk("ind_level_e5", 32'(bus.level), 32'h00);
        tick(1);
        chk("ind_level_b3", 32'(bus.level), 32'h08);
        chk("ind_press_b3", 32'(bus.press), 32'h08);
        tick(1);
        chk("ind_level_b34", 32'(bus.level),  32'h18);
        chk("ind_press_b4",  32'(bus.press),  32'h10);
        chk("ind_strobe_b4", 32'(bus.strobe), 32'h10);
        tick(1);
        chk("ind_press_end", 32'(bus.press), 32'h00);
        bus.btn_raw = 5'b11111;
        tick(6);
        chk("ind_rel_level", 32'(bus.level),     32'h00);
        chk("ind_rel_pulse", 32'(bus.release_p), 32'h18);
        tick(1);
        clear_pulse();
        chk("ind_clear", 32'(bus.events), 32'h00);

        // ---- Reset while bit0 is in auto-repeat
        bus.btn_raw = 5'b11110;
        tick(6);                                            // P
        chk("mid_press", 32'(bus.press), 32'h01);
        tick(10);                                           // P+10
        chk("mid_rep1", 32'(bus.strobe), 32'h01);
        tick(1);                                            // P+11
        chk("mid_state_rep", 32'(u_dut.g_chan[0].u_ch.rep_state_q), 32'(REPEAT));
        chk("mid_events",    32'(bus.events), 32'h01);
        reset = 1'b0;
        tick(1);
        chk("mid_rst_level",  32'(bus.level),     32'h00);
        chk("mid_rst_press",  32'(bus.press),     32'h00);
        chk("mid_rst_rel",    32'(bus.release_p), 32'h00);
        chk("mid_rst_strobe", 32'(bus.strobe),    32'h00);
        chk("mid_rst_events", 32'(bus.events),    32'h00);
        chk("mid_rst_state",  32'(u_dut.g_chan[0].u_ch.rep_state_q), 32'(IDLE));
        reset = 1'b1;
        tick(5);
        chk("mid_repress_e5", 32'(bus.level), 32'h00);
        tick(1);
        chk("mid_repress_level", 32'(bus.level), 32'h01);
        chk("mid_repress_press", 32'(bus.press), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
